// File: rtl/frame_packet_aligner_pkg.sv
// Shared video definitions for the frame packet aligner.
// Holds default image geometry, pixel width, pixel counter width,
// the aligner FSM state encoding and the pixel type.
package frame_packet_aligner_pkg;

   localparam int VID_PIXEL_W      = 12;   // RGB444
   localparam int VID_IMAGE_WIDTH  = 320;
   localparam int VID_IMAGE_HEIGHT = 240;
   localparam int VID_CNT_W        = 17;   // holds 320*240-1

   typedef logic [VID_PIXEL_W-1:0] pixel_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_STREAM  = 2'd1,
      ST_PAD     = 2'd2,
      ST_DISCARD = 2'd3
   } fpa_state_t;

endpackage

// File: rtl/stream_skid_buffer.sv
// Two-entry registered skid stage for a valid/ready stream.
// Ports:
//   clk, reset_n           clock, async active-low reset
//   in_valid/in_ready/in_data     sink side
//   out_valid/out_ready/out_data  source side (registered)
// in_ready is a pure register (not combinational on out_ready), so the
// upstream ready path is cut; one extra entry absorbs the beat that was
// already in flight when out_ready dropped.
module stream_skid_buffer #(
   parameter int DW = 14
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data
);

   logic          r_out_valid;
   logic [DW-1:0] r_out_data;
   logic          r_skid_valid;
   logic [DW-1:0] r_skid_data;
   logic          w_in_xfer;

   assign in_ready  = ~r_skid_valid;
   assign w_in_xfer = in_valid & ~r_skid_valid;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_skid_valid <= 1'b0;
         r_skid_data  <= '0;
      end else if (!r_out_valid || out_ready) begin
         // Output register free this cycle: drain skid first to keep order.
         if (r_skid_valid) begin
            r_out_valid  <= 1'b1;
            r_out_data   <= r_skid_data;
            r_skid_valid <= 1'b0;
         end else begin
            r_out_valid <= w_in_xfer;
            if (w_in_xfer) begin
               r_out_data <= in_data;
            end
         end
      end else if (w_in_xfer) begin
         r_skid_valid <= 1'b1;
         r_skid_data  <= in_data;
      end
   end

endmodule

// File: rtl/frame_packet_aligner.sv
// Frame packet aligner: forces every output frame to exactly
// IMAGE_WIDTH*IMAGE_HEIGHT beats. Short frames are padded with zero
// pixels, long frames are truncated and their tail discarded.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   valid_in, startofpacket_in, endofpacket_in, data_in, ready_out
//                                upstream pixel stream (sink)
//   valid_out, startofpacket_out, endofpacket_out, data_out, ready_in
//                                frame-exact stream (source, registered)
//   short_frame                  1-cycle pulse when a frame gets padded
//   long_frame                   1-cycle pulse when a frame gets truncated
//
// state      | meaning
// -----------+-------------------------------------------------------
// ST_IDLE    | waiting for a sop beat; non-sop beats are dropped
// ST_STREAM  | forwarding beats of the current frame
// ST_PAD     | upstream ended early; emitting zero pixels to fill frame
// ST_DISCARD | frame already complete; dropping upstream until eop
module frame_packet_aligner
   import frame_packet_aligner_pkg::*;
#(
   parameter int IMAGE_WIDTH  = VID_IMAGE_WIDTH,
   parameter int IMAGE_HEIGHT = VID_IMAGE_HEIGHT,
   parameter int PIXEL_W      = VID_PIXEL_W
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               valid_in,
   input  logic               startofpacket_in,
   input  logic               endofpacket_in,
   input  logic [PIXEL_W-1:0] data_in,
   output logic               ready_out,
   output logic               valid_out,
   output logic               startofpacket_out,
   output logic               endofpacket_out,
   output logic [PIXEL_W-1:0] data_out,
   input  logic               ready_in,
   output logic               short_frame,
   output logic               long_frame
);

   localparam int                   TOTAL    = IMAGE_WIDTH * IMAGE_HEIGHT;
   localparam logic [VID_CNT_W-1:0] LAST_IDX = VID_CNT_W'(TOTAL - 1);

   fpa_state_t           r_state;
   logic [VID_CNT_W-1:0] r_cnt;
   logic                 r_run;
   logic                 r_short;
   logic                 r_long;

   logic                 w_ready;
   logic                 w_skid_ready;
   logic                 w_push_valid;
   logic [PIXEL_W-1:0]   w_push_data;
   logic                 w_push_sop;
   logic                 w_push_eop;
   logic                 w_push_xfer;
   logic                 w_sink_xfer;
   logic                 w_sop_in;
   logic                 w_last;
   logic [PIXEL_W+1:0]   w_skid_out;

   assign w_sop_in = valid_in & startofpacket_in;
   assign w_last   = (r_cnt == LAST_IDX);

   always_comb begin
      w_ready      = 1'b0;
      w_push_valid = 1'b0;
      w_push_data  = '0;
      w_push_sop   = 1'b0;
      w_push_eop   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_ready      = r_run & w_skid_ready;
            w_push_valid = w_sop_in & w_ready;
            w_push_data  = data_in;
            w_push_sop   = 1'b1;
            w_push_eop   = w_last;   // counter is 0 here: only true for 1-beat frames
         end
         ST_STREAM: begin
            // A new sop mid-frame is held off so IDLE can take it later.
            w_ready      = r_run & w_skid_ready & ~w_sop_in;
            w_push_valid = valid_in & w_ready;
            w_push_data  = data_in;
            w_push_eop   = w_last;
         end
         ST_PAD: begin
            w_push_valid = 1'b1;
            w_push_eop   = w_last;
         end
         ST_DISCARD: begin
            w_ready = r_run & w_skid_ready & ~w_sop_in;
         end
         default: begin
            w_ready = 1'b0;
         end
      endcase
   end

   assign w_sink_xfer = valid_in & w_ready;
   assign w_push_xfer = w_push_valid & w_skid_ready;
   assign ready_out   = w_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_run   <= 1'b0;
         r_short <= 1'b0;
         r_long  <= 1'b0;
      end else begin
         r_run   <= 1'b1;
         r_short <= 1'b0;
         r_long  <= 1'b0;
         case (r_state)
            ST_IDLE, ST_STREAM: begin
               if (r_state == ST_STREAM && w_sop_in) begin
                  r_state <= ST_PAD;
                  r_short <= 1'b1;
               end else if (w_push_xfer) begin
                  if (w_last) begin
                     r_cnt <= '0;
                     if (endofpacket_in) begin
                        r_state <= ST_IDLE;
                     end else begin
                        r_state <= ST_DISCARD;
                        r_long  <= 1'b1;
                     end
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                     if (endofpacket_in) begin
                        r_state <= ST_PAD;
                        r_short <= 1'b1;
                     end else begin
                        r_state <= ST_STREAM;
                     end
                  end
               end
            end
            ST_PAD: begin
               if (w_push_xfer) begin
                  if (w_last) begin
                     r_cnt   <= '0;
                     r_state <= ST_IDLE;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            ST_DISCARD: begin
               if (w_sop_in || (w_sink_xfer && endofpacket_in)) begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   stream_skid_buffer #(
      .DW (PIXEL_W + 2)
   ) u_skid (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (w_push_valid),
      .in_ready  (w_skid_ready),
      .in_data   ({w_push_sop, w_push_eop, w_push_data}),
      .out_valid (valid_out),
      .out_ready (ready_in),
      .out_data  (w_skid_out)
   );

   assign startofpacket_out = w_skid_out[PIXEL_W+1];
   assign endofpacket_out   = w_skid_out[PIXEL_W];
   assign data_out          = w_skid_out[PIXEL_W-1:0];
   assign short_frame       = r_short;
   assign long_frame        = r_long;

endmodule
